// File: rtl/nfa_alt_literal_engine.sv
// Alternation-of-literals NFA matcher: one shift-chain of prefix states per literal,
// with per-alternative hit reporting, match/byte counters and first-match offset.
module nfa_alt_literal_engine #(
    parameter int unsigned                     NUM_ALT  = 2,
    parameter int unsigned                     MAX_LEN  = 4,
    parameter logic [NUM_ALT*MAX_LEN*8-1:0]    PATTERNS = '0,
    parameter logic [NUM_ALT*4-1:0]            LENGTHS  = '0,
    parameter bit                              NOCASE   = 1'b1,
    parameter bit                              ANCHORED = 1'b0,
    parameter bit                              STICKY   = 1'b1,
    parameter int unsigned                     CNT_W    = 16
) (
    input  logic               clk,
    input  logic               sod,
    input  logic               en,
    input  logic [7:0]         char,
    output logic               out,
    output logic               match_pulse,
    output logic [NUM_ALT-1:0] match_id,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [CNT_W-1:0]   first_pos,
    output logic [CNT_W-1:0]   byte_cnt
);

    function automatic logic is_letter(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic logic cm(input logic [7:0] p, input logic [7:0] c);
        if (NOCASE && is_letter(p) && is_letter(c))
            return (p | 8'h20) == (c | 8'h20);
        return p == c;
    endfunction

    function automatic int unsigned clamp_len(input int unsigned a);
        int unsigned l;
        l = int'(LENGTHS[a*4 +: 4]);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    logic [NUM_ALT-1:0] hit;
    logic               any_hit;
    logic               start_ok;

    // Anchoring only gates new starts; chains already in flight keep advancing.
    assign start_ok = ANCHORED ? (byte_cnt == '0) : 1'b1;
    assign any_hit  = |hit;

    for (genvar a = 0; a < NUM_ALT; a++) begin : g_alt
        localparam int unsigned LEN = clamp_len(a);

        if (LEN == 0) begin : g_off
            assign hit[a] = 1'b0;
        end else begin : g_on
            logic [LEN-1:0] cmv;

            always_comb begin
                cmv = '0;
                for (int unsigned k = 0; k < LEN; k++)
                    cmv[k] = cm(PATTERNS[(a*MAX_LEN+k)*8 +: 8], char);
            end

            if (LEN == 1) begin : g_single
                assign hit[a] = en & cmv[0] & start_ok;
            end else begin : g_chain
                // st[k]: bytes 0..k of this literal matched up to the previous enabled byte
                logic [LEN-2:0] st;

                always_ff @(posedge clk) begin
                    if (!sod) begin
                        st <= '0;
                    end else if (en) begin
                        st[0] <= cmv[0] & start_ok;
                        for (int unsigned k = 1; k < LEN - 1; k++)
                            st[k] <= cmv[k] & st[k-1];
                    end
                end

                assign hit[a] = en & cmv[LEN-1] & st[LEN-2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sod) begin
            out         <= 1'b0;
            match_pulse <= 1'b0;
            match_id    <= '0;
            match_cnt   <= '0;
            first_pos   <= '0;
            byte_cnt    <= '0;
        end else if (en) begin
            match_pulse <= any_hit;
            match_id    <= hit;
            out         <= STICKY ? (out | any_hit) : any_hit;
            if (byte_cnt != '1)
                byte_cnt <= byte_cnt + 1'b1;
            if (any_hit) begin
                if (match_cnt != '1)
                    match_cnt <= match_cnt + 1'b1;
                if (match_cnt == '0)
                    first_pos <= byte_cnt;
            end
        end else begin
            match_pulse <= 1'b0;
            match_id    <= '0;
            if (!STICKY)
                out <= 1'b0;
        end
    end

endmodule

// File: doc/nfa_alt_literal_engine.md
Name: nfa_alt_literal_engine

Overview:
- Parametrised NFA match engine for the regex `/lit0|lit1|...|litN-1/` over a byte stream, one byte per enabled clock.
- Each alternative is a literal string of up to MAX_LEN bytes. Case folding, start anchoring and sticky/pulse output are selectable.
- Sits in the engine array beside the single-character-class engines and consumes the same char/en/sod stream.
- Adds per-alternative hit reporting, a match counter, a byte counter and the offset of the first match.

Parameters:
- NUM_ALT, 2, number of alternatives (1..8).
- MAX_LEN, 4, maximum literal length in bytes (1..15).
- PATTERNS, 0, NUM_ALT*MAX_LEN*8 bits. Byte k of alternative a is at bits [(a*MAX_LEN+k)*8 +: 8]. Byte 0 is the first character.
- LENGTHS, 0, NUM_ALT*4 bits. Field a is at [a*4 +: 4] and gives the length of alternative a. A value of 0 disables that alternative. Values above MAX_LEN are clamped to MAX_LEN.
- NOCASE, 1, 1 selects case-insensitive compare for A-Z/a-z only.
- ANCHORED, 0, 1 allows a match to start only at the first enabled byte after reset.
- STICKY, 1, 1 makes `out` latch until reset; 0 makes `out` a one-cycle pulse.
- CNT_W, 16, width of the counters.

Ports:
- clk  in  1  rising-edge clock.
- sod  in  1  start-of-data; synchronous, active-low reset (0 clears all state at the clock edge).
- en  in  1  byte-valid; state advances only when en=1.
- char  in  8  input byte.
- out  out  1  match flag (sticky or pulse according to STICKY).
- match_pulse  out  1  one-cycle pulse for each enabled byte that completes at least one alternative.
- match_id  out  NUM_ALT  per-alternative completion bits for that same byte.
- match_cnt  out  CNT_W  number of enabled bytes that produced a match; saturating.
- first_pos  out  CNT_W  byte index of the final byte of the first match.
- byte_cnt  out  CNT_W  number of enabled bytes consumed since reset; saturating.

Behaviour:
- Reset (sod=0 at a clock edge): every state bit, out, match_pulse, match_id, match_cnt, first_pos and byte_cnt become 0. Reset overrides en. A reset in the middle of a partial match discards it.
- Character compare `cm(a,k)`:
  - Exact 8-bit equality with the pattern byte.
  - If NOCASE=1 and both the pattern byte and char are letters, compare with bit 5 ignored.
  - Non-letters always compare exactly.
- State bits `s[a][k]`, k = 0..len_a-2, where `s[a][k]` = bytes 0..k of alternative a matched, ending at the previous enabled byte.
- `start_ok` = 1 when ANCHORED=0; when ANCHORED=1, `start_ok` = (byte_cnt==0).
- On an enabled edge:
  - `s[a][0] <= cm(a,0) & start_ok`.
  - `s[a][k] <= cm(a,k) & s[a][k-1]`.
- Combinational hit:
  - `hit[a] = cm(a,len_a-1) & (len_a==1 ? start_ok : s[a][len_a-2])`.
  - `hit[a]` is forced to 0 if len_a==0 or en=0.
- Overlapping matches are found: all prefixes are tracked in parallel, with no consumption on match.
- Latency: 1 clock. On the edge where the final byte is presented with en=1:
  - match_pulse <= |hit and match_id <= hit.
  - out <= STICKY ? (out | (|hit)) : (|hit).
- When en=0: state bits, counters, first_pos and a sticky out hold their values. match_pulse, match_id and a non-sticky out go to 0.
- byte_cnt increments on every enabled byte and saturates at all-ones.
- match_cnt increments by 1 per enabled byte with |hit, even when several alternatives hit together, and saturates.
- first_pos is loaded with the pre-increment byte_cnt on the first hit after reset (match_cnt==0) and is then frozen.
- In ANCHORED mode, once byte_cnt is nonzero no new match can start; matches already in progress may still complete.

Test Plan:
- NUM_ALT=2, PATTERNS="m","n", LENGTHS=1,1, NOCASE=1, STICKY=1; reset, then stream "xxNz" -> match_pulse high one cycle after 'N'; match_id=2'b10; out stays 1 through 'z'; match_cnt=1; first_pos=2.
- MAX_LEN=3, literals "abc" and "bcd", stream "abcd" -> match_id=01 after 'c' and 10 after 'd'; match_cnt=2; first_pos=2.
- Literal "aa", stream "aaaa" with STICKY=0 -> out pulses after bytes 1, 2 and 3; match_cnt=3.
- Literal "ab", stream a, en=0 for 3 cycles, b -> match after 'b'; no pulse during the en=0 cycles; byte_cnt=2.
- ANCHORED=1, literal "ab", stream "xab" -> no match, out=0, match_cnt=0. Then sod=0 for one cycle and stream "ab" -> match, first_pos=1.
- Reset mid-match: literal "abc", stream a, b, sod=0, c -> no match; all outputs 0 in the cycle after reset. NOCASE=0 with "m" vs 'M' -> no match.
